// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM state encoding, destination ID width and default broadcast ID
package bus_arb_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_DEF = 8'hFF;
  typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, PUSH = 2'd2} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks one requester, searching upward from ptr with wrap-around, or from 0 when fixed
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          fixed,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  localparam logic [IW:0] NW = (IW+1)'(N);
  logic [IW:0] start, sum;
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    start = fixed ? '0 : {1'b0, ptr};
    for (int i = 0; i < N; i++) begin
      sum = start + (IW+1)'(i);
      j = sum >= NW ? IW'(sum - NW) : IW'(sum);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: moves one head packet per 3 cycles from a pending port to its destination port(s)
module bus_rr_arbiter import bus_arb_pkg::*; #(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEF,
  parameter int              PRIO_MODE = 0
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [7:0]               drop_cnt
);
  localparam int IW = drvrs > 1 ? $clog2(drvrs) : 1;
  localparam logic [IW-1:0] LAST = IW'(drvrs - 1);
  localparam logic [drvrs-1:0] ONE = drvrs'(1);
  localparam logic [ID_W-1:0] NDRV = ID_W'(drvrs);
  state_t state;
  logic [IW-1:0] ptr, src, w_idx;
  logic [drvrs-1:0] w_gnt, dst;
  logic [pckg_sz-1:0] pkt;
  logic [pckg_sz-1:0] slot [drvrs];
  logic [ID_W-1:0] dest;
  logic bcast, valid, drop;
  for (genvar g = 0; g < drvrs; g++) begin : g_slot
    assign slot[g] = D_pop[g*pckg_sz +: pckg_sz];
  end
  rr_arbiter #(.N(drvrs), .IW(IW)) u_arb (
    .req   (pndng),
    .ptr   (ptr),
    .fixed (PRIO_MODE != 0),
    .gnt   (w_gnt),
    .idx   (w_idx)
  );
  // Unknown destinations and packets addressed back to their source are dropped
  always_comb begin
    dest  = pkt[pckg_sz-1 -: ID_W];
    bcast = dest == broadcast;
    valid = dest < NDRV && dest != ID_W'(src);
    dst   = bcast ? ~(ONE << src) : valid ? ONE << dest : '0;
    drop  = !bcast && !valid;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      drop_cnt <= '0;
      ptr      <= '0;
      pkt      <= '0;
      src      <= '0;
    end else begin
      case (state)
        IDLE: if (|pndng) begin
          state <= POP;
          busy  <= 1'b1;
          pop   <= w_gnt;
          pkt   <= slot[w_idx];
          src   <= w_idx;
          ptr   <= w_idx == LAST ? '0 : w_idx + 1'b1;
        end
        POP: begin
          state  <= PUSH;
          pop    <= '0;
          push   <= dst;
          D_push <= pkt;
          if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          push  <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed vectors for round-robin and fixed-priority instances sharing stimulus
module tb_bus_rr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] pndng = '0;
  logic [63:0] d_pop = '0;
  logic [3:0] pop, push, pop_f, push_f;
  logic [15:0] d_push, d_push_f;
  logic busy, busy_f;
  logic [7:0] drop_cnt, drop_cnt_f;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bus_rr_arbiter #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .PRIO_MODE(0)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop), .push(push), .D_push(d_push), .busy(busy), .drop_cnt(drop_cnt)
  );
  bus_rr_arbiter #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .PRIO_MODE(1)) dut_f (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop_f), .push(push_f), .D_push(d_push_f), .busy(busy_f), .drop_cnt(drop_cnt_f)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_pop", 32'(pop), 32'h0);
    check("rst_push", 32'(push), 32'h0);
    check("rst_dpush", 32'(d_push), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    tick;
    reset = 1'b1;
    // unicast port 0 -> port 2
    d_pop[15:0] = 16'h02AB;
    pndng = 4'b0001;
    tick;
    check("uni_pop", 32'(pop), 32'h1);
    check("uni_busy", 32'(busy), 32'h1);
    check("uni_push0", 32'(push), 32'h0);
    pndng = 4'b0000;
    tick;
    check("uni_pop_end", 32'(pop), 32'h0);
    check("uni_push", 32'(push), 32'h4);
    check("uni_dpush", 32'(d_push), 32'h02AB);
    tick;
    check("uni_push_end", 32'(push), 32'h0);
    check("uni_idle", 32'(busy), 32'h0);
    check("uni_hold", 32'(d_push), 32'h02AB);
    // broadcast from port 1
    d_pop[31:16] = 16'hFF55;
    pndng = 4'b0010;
    tick;
    check("bc_pop", 32'(pop), 32'h2);
    pndng = 4'b0000;
    tick;
    check("bc_push", 32'(push), 32'hD);
    check("bc_dpush", 32'(d_push), 32'hFF55);
    check("bc_drop", 32'(drop_cnt), 32'h0);
    tick;
    // round-robin versus fixed priority from a fresh pointer
    reset = 1'b0;
    #1;
    reset = 1'b1;
    d_pop = {4{16'hFF00}};
    pndng = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      check($sformatf("rr_gnt%0d", k), 32'(pop), 32'(4'b0001 << (k % 4)));
      check($sformatf("fix_gnt%0d", k), 32'(pop_f), 32'h1);
      tick;
      tick;
    end
    pndng = 4'b0000;
    tick;
    // invalid destinations: out of range, then self
    d_pop[47:32] = 16'h07CD;
    d_pop[63:48] = 16'h0312;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    pndng = 4'b0100;
    tick;
    pndng = 4'b0000;
    tick;
    check("bad_push", 32'(push), 32'h0);
    tick;
    pndng = 4'b1000;
    tick;
    check("self_pop", 32'(pop), 32'h8);
    pndng = 4'b0000;
    tick;
    check("self_push", 32'(push), 32'h0);
    check("drop2", 32'(drop_cnt), 32'h2);
    tick;
    pndng = 4'b0100;
    repeat (258 * 3) tick;
    pndng = 4'b0000;
    check("drop_sat", 32'(drop_cnt), 32'hFF);
    check("drop_sat_f", 32'(drop_cnt_f), 32'hFF);
    // reset during POP
    d_pop[47:32] = 16'h0112;
    pndng = 4'b0100;
    tick;
    check("mid_pop", 32'(pop), 32'h4);
    reset = 1'b0;
    #1;
    check("mid_pop_clr", 32'(pop), 32'h0);
    check("mid_push_clr", 32'(push), 32'h0);
    check("mid_busy_clr", 32'(busy), 32'h0);
    check("mid_drop_clr", 32'(drop_cnt), 32'h0);
    pndng = 4'b0000;
    tick;
    tick;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("mid_nopush%0d", k), 32'(push), 32'h0);
    end
    d_pop = {4{16'hFF00}};
    pndng = 4'b1111;
    tick;
    check("mid_resume", 32'(pop), 32'h1);
    pndng = 4'b0000;
    tick;
    tick;
    // idle
    for (int k = 0; k < 20; k++) begin
      tick;
      check($sformatf("idle%0d", k), 32'({busy, pop, push}), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter drvrs, default 4: number of bus drivers/ports.
REQ-002 SHALL have parameter pckg_sz, default 16: packet width in bits; destination ID is bits [pckg_sz-1 -: 8].
REQ-003 SHALL have parameter broadcast, default 8'hFF: destination ID meaning "all ports".
REQ-004 SHALL have parameter PRIO_MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port pndng, input, drvrs bits: port i has a packet waiting at its FIFO head.
REQ-008 SHALL have port D_pop, input, drvrs*pckg_sz bits: head packet of port i in slice i.
REQ-009 SHALL have port pop, output, drvrs bits: one-cycle consume strobe to port i.
REQ-010 SHALL have port push, output, drvrs bits: one-cycle delivery strobe to port i.
REQ-011 SHALL have port D_push, output, pckg_sz bits: packet being delivered, common to all ports.
REQ-012 SHALL have port busy, output, 1 bit: FSM not in IDLE.
REQ-013 SHALL have port drop_cnt, output, 8 bits: saturating count of dropped packets.

Function
REQ-014 SHALL implement FSM states IDLE, POP, PUSH.
REQ-015 IDLE: if any pndng bit is set, SHALL select winner w, latch D_pop slice w and its source index, and enter POP; otherwise SHALL remain in IDLE.
REQ-016 POP: SHALL drive pop[w]=1 for exactly one cycle, then enter PUSH.
REQ-017 PUSH: SHALL drive D_push=latched packet for one cycle and assert push on the destination set, then enter IDLE.
REQ-018 Latency SHALL be: pndng sampled at edge N; pop high in cycle N..N+1; push high in cycle N+1..N+2. Peak throughput SHALL be one packet per 3 cycles.
REQ-019 Round-robin mode: after granting w, SHALL give highest priority to (w+1) mod drvrs and search upward with wrap-around.
REQ-020 Fixed mode: SHALL grant the lowest set index of pndng; the round-robin pointer SHALL be ignored.
REQ-021 Destination ID < drvrs and not equal to source: push SHALL be one-hot at the ID.
REQ-022 Destination ID == broadcast: push SHALL be asserted on all ports except the source.
REQ-023 Destination ID >= drvrs (non-broadcast) or ID == source: push SHALL stay 0 in PUSH, and drop_cnt SHALL increment, saturating at 255.
REQ-024 pndng changes during POP/PUSH SHALL be ignored until IDLE is re-entered.
REQ-025 Outside POP, pop SHALL be 0; outside PUSH, push SHALL be 0. D_push SHALL hold its last value when push is 0.

Reset
REQ-026 On reset low, all of the following SHALL take effect immediately, regardless of clk: FSM=IDLE, pop=0, push=0, D_push=0, busy=0, drop_cnt=0, round-robin pointer=0.
REQ-027 Reset asserted mid-transfer SHALL abandon the in-flight packet without any push.
REQ-028 Arbitration SHALL resume on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package bus_arb_pkg SHALL hold the FSM state enum, the ID width constant (8), and the default broadcast value.
REQ-030 Winner selection SHALL be a sub-module rr_arbiter (request vector, pointer, mode in; one-hot grant and index out).
REQ-031 The RTL SHALL be synthesizable with no latches, and all outputs SHALL be registered.

Verification (drvrs=4, pckg_sz=16)
REQ-032 Unicast: port 0 holds 16'h02AB -> pop[0] one cycle later, then push=4'b0100 with D_push=16'h02AB.
REQ-033 Broadcast: port 1 holds 16'hFF55 -> push=4'b1101 with D_push=16'hFF55, drop_cnt unchanged.
REQ-034 Round-robin: all pndng=4'b1111 held -> grant order 0,1,2,3,0; with PRIO_MODE=1 -> grant order 0,0,0.
REQ-035 Invalid destination: port 2 holds 16'h07CD, then port 3 holds 16'h0312 (self) -> no push, drop_cnt=2; after 260 drops, drop_cnt=255.
REQ-036 Reset mid-transfer: reset low during POP -> pop=push=0 immediately, busy=0, no push after release; next pndng serviced normally, starting from port 0.
REQ-037 Idle: pndng=0 for 20 cycles -> busy, pop and push stay 0.
